// File: rtl/bitmap_pkg.sv
// Shared state encoding and default geometry for the bitmap write path.
package bitmap_pkg;
  localparam int BMP_ABITS = 12;
  localparam int BMP_DBITS = 12;
  localparam int BMP_NLOC  = 2560;

  typedef enum logic [1:0] {
    BW_IDLE   = 2'd0,
    BW_WRITE  = 2'd1,
    BW_FINISH = 2'd2
  } bw_state_t;
endpackage

// File: rtl/bitmap_fill_writer_if.sv
// Command, status and RAM write-port bundle for the bitmap fill engine.
// alt_color exists only when BITMAP_WR_CHECKER_EN is defined.
interface bitmap_fill_writer_if #(
  parameter int Abits = bitmap_pkg::BMP_ABITS,
  parameter int Dbits = bitmap_pkg::BMP_DBITS
);
  logic             start;
  logic [Abits-1:0] start_addr;
  logic [Abits-1:0] count;
  logic [Dbits-1:0] fill_color;
`ifdef BITMAP_WR_CHECKER_EN
  logic [Dbits-1:0] alt_color;
`endif
  logic             cancel;
  logic             busy;
  logic             done;
  logic             err;

  // RAM write handshake: a word transfers on every rising edge where mem_we and
  // mem_ready are both 1. While mem_we=1 and mem_ready=0 the engine holds
  // mem_addr, mem_wdata and mem_we unchanged; only cancel may withdraw mem_we.
  logic             mem_we;
  logic             mem_ready;
  logic [Abits-1:0] mem_addr;
  logic [Dbits-1:0] mem_wdata;

  // master: the fill engine (write master towards the RAM)
  modport master (
`ifdef BITMAP_WR_CHECKER_EN
    input  alt_color,
`endif
    input  start, start_addr, count, fill_color, cancel, mem_ready,
    output busy, done, err, mem_we, mem_addr, mem_wdata
  );

  // slave: the controller plus RAM side that drives commands and mem_ready
  modport slave (
`ifdef BITMAP_WR_CHECKER_EN
    output alt_color,
`endif
    output start, start_addr, count, fill_color, cancel, mem_ready,
    input  busy, done, err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/bitmap_addr_gen.sv
// Loadable write-address / remaining-word counter for the bitmap fill engine.
module bitmap_addr_gen #(
  parameter int Abits = bitmap_pkg::BMP_ABITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Abits-1:0] load_addr,
  input  logic [Abits-1:0] load_count,
  input  logic             advance,
  input  logic             clear,
  output logic [Abits-1:0] addr,
  output logic             last
);
  logic [Abits-1:0] remaining;

  // The address stops on the final word so it never steps past the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_count;
    end else if (clear) begin
      remaining <= '0;
    end else if (advance) begin
      remaining <= remaining - Abits'(1);
      if (!last) addr <= addr + Abits'(1);
    end
  end

  assign last = (remaining == Abits'(1));
endmodule

// File: rtl/bitmap_fill_writer.sv
// Bitmap fill engine: writes one colour to a contiguous run of bitmap words.
// Define BITMAP_WR_CHECKER_EN to alternate fill/alt colour on address parity.
module bitmap_fill_writer
  import bitmap_pkg::*;
#(
  parameter int Abits = BMP_ABITS,
  parameter int Dbits = BMP_DBITS,
  parameter int Nloc  = BMP_NLOC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitmap_fill_writer_if.master bus,
  output bw_state_t            state_dbg
);
  localparam logic [Abits:0] NLOC_EXT = (Abits+1)'(Nloc);

  bw_state_t        state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             we_q, we_d;
  logic [Dbits-1:0] wdata_q, wdata_d;
  logic             load, advance, clear, last, accept;
  logic [Abits-1:0] addr;
  logic [Abits:0]   run_end;

`ifdef BITMAP_WR_CHECKER_EN
  logic [Dbits-1:0] fill_q, alt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      alt_q  <= '0;
    end else if (load) begin
      fill_q <= bus.fill_color;
      alt_q  <= bus.alt_color;
    end
  end
`endif

  // One extra bit keeps start_addr+count from wrapping in the range check.
  assign run_end = {1'b0, bus.start_addr} + {1'b0, bus.count};
  assign accept  = we_q & bus.mem_ready;

  bitmap_addr_gen #(.Abits(Abits)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_addr  (bus.start_addr),
    .load_count (bus.count),
    .advance    (advance),
    .clear      (clear),
    .addr       (addr),
    .last       (last)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      BW_IDLE: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            done_d = 1'b1;
          end else if (run_end > NLOC_EXT) begin
            err_d = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = BW_WRITE;
            busy_d  = 1'b1;
            we_d    = 1'b1;
`ifdef BITMAP_WR_CHECKER_EN
            wdata_d = bus.start_addr[0] ? bus.alt_color : bus.fill_color;
`else
            wdata_d = bus.fill_color;
`endif
          end
        end
      end
      BW_WRITE: begin
        // Cancel wins over a same-cycle acceptance; that word still landed.
        if (bus.cancel) begin
          clear   = 1'b1;
          state_d = BW_IDLE;
          busy_d  = 1'b0;
          we_d    = 1'b0;
        end else if (accept) begin
          advance = 1'b1;
          if (last) begin
            state_d = BW_FINISH;
            busy_d  = 1'b0;
            we_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
`ifdef BITMAP_WR_CHECKER_EN
            // Next address has the opposite parity of the current one.
            wdata_d = addr[0] ? fill_q : alt_q;
`endif
          end
        end
      end
      BW_FINISH: begin
        state_d = BW_IDLE;
      end
      default: begin
        state_d = BW_IDLE;
        busy_d  = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BW_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_bitmap_fill_writer.sv
// Directed self-checking bench for bitmap_fill_writer (either build of
// BITMAP_WR_CHECKER_EN); a negedge monitor scores every accepted write.
module tb_bitmap_fill_writer
  import bitmap_pkg::*;
;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam int W  = AW + DW;

  logic      clk;
  logic      rst_n;
  bw_state_t state_dbg;

  bitmap_fill_writer_if #(.Abits(AW), .Dbits(DW)) bus ();

  bitmap_fill_writer #(.Abits(AW), .Dbits(DW), .Nloc(2560)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int we_cycles, accepts, done_cnt, err_cnt, busy_cycles;
  int last_acc_cyc, done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a,
                                             input logic [DW-1:0] f,
                                             input logic [DW-1:0] al);
`ifdef BITMAP_WR_CHECKER_EN
    return a[0] ? al : f;
`else
    return (al == al) ? f : f;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) we_cycles++;
      if (bus.busy) busy_cycles++;
      if (bus.mem_we && bus.mem_ready) begin
        logic [W-1:0] e;
        accepts++;
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {20'd0, bus.mem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {20'd0, bus.mem_addr}, {20'd0, e[W-1:DW]});
          check("wr_data", {20'd0, bus.mem_wdata}, {20'd0, e[DW-1:0]});
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", {31'd0, bus.busy}, 32'd0);
      end
      if (bus.err) err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    exp_q.delete();
    we_cycles = 0; accepts = 0; done_cnt = 0; err_cnt = 0; busy_cycles = 0;
    last_acc_cyc = -1; done_cyc = -1;
  endtask

  task automatic push_run(input int a, input int n, input logic [DW-1:0] f, input logic [DW-1:0] al);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] ad;
      ad = AW'(a + i);
      exp_q.push_back({ad, exp_data(ad, f, al)});
    end
  endtask

  // Start pulse for one cycle, then scramble the command inputs.
  task automatic issue(input int a, input int n, input logic [DW-1:0] f, input logic [DW-1:0] al);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.start_addr = AW'(a);
    bus.count      = AW'(n);
    bus.fill_color = f;
`ifdef BITMAP_WR_CHECKER_EN
    bus.alt_color  = al;
`endif
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.start_addr = AW'($urandom_range(0, 4095));
    bus.count      = AW'($urandom_range(0, 4095));
    bus.fill_color = DW'($urandom_range(0, 4095));
`ifdef BITMAP_WR_CHECKER_EN
    bus.alt_color  = DW'($urandom_range(0, 4095));
`endif
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {31'd0, n < budget}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.count      = '0;
    bus.fill_color = '0;
`ifdef BITMAP_WR_CHECKER_EN
    bus.alt_color  = '0;
`endif
    bus.cancel     = 1'b0;
    bus.mem_ready  = 1'b1;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("rst_we",    {31'd0, bus.mem_we}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_done",  {31'd0, bus.done}, 32'd0);
    check("rst_err",   {31'd0, bus.err}, 32'd0);
    check("rst_addr",  {20'd0, bus.mem_addr}, 32'd0);
    check("rst_wdata", {20'd0, bus.mem_wdata}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, BW_IDLE});
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic fill: 10..13 with F00
    clear_stats();
    push_run(10, 4, 12'hF00, 12'hF00);
    issue(10, 4, 12'hF00, 12'hF00);
    check("basic_busy", {31'd0, bus.busy}, 32'd1);
    wait_quiet("basic_timeout", 50);
    check("basic_accepts", accepts, 4);
    check("basic_we_cycles", we_cycles, 4);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_done_lat", done_cyc, last_acc_cyc + 1);
    check("basic_err_cnt", err_cnt, 0);
    check("basic_left", exp_q.size(), 0);

    // Back-pressure on the second write cycle
    clear_stats();
    push_run(0, 3, 12'h0A5, 12'h0A5);
    issue(0, 3, 12'h0A5, 12'h0A5);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_hold_addr", {20'd0, bus.mem_addr}, 32'd1);
    check("bp_hold_we", {31'd0, bus.mem_we}, 32'd1);
    bus.mem_ready = 1'b1;
    wait_quiet("bp_timeout", 50);
    check("bp_accepts", accepts, 3);
    check("bp_we_cycles", we_cycles, 4);
    check("bp_done_cnt", done_cnt, 1);
    check("bp_done_lat", done_cyc, last_acc_cyc + 1);
    check("bp_left", exp_q.size(), 0);

    // Range error: 2558+3 > 2560
    clear_stats();
    issue(2558, 3, 12'h123, 12'h123);
    wait_quiet("range_timeout", 50);
    check("range_err_cnt", err_cnt, 1);
    check("range_done_cnt", done_cnt, 0);
    check("range_we_cycles", we_cycles, 0);
    check("range_busy", busy_cycles, 0);

    // Boundary: 2557..2559 exactly fits
    clear_stats();
    push_run(2557, 3, 12'h0F0, 12'h0F0);
    issue(2557, 3, 12'h0F0, 12'h0F0);
    wait_quiet("edge_timeout", 50);
    check("edge_accepts", accepts, 3);
    check("edge_done_cnt", done_cnt, 1);
    check("edge_err_cnt", err_cnt, 0);
    check("edge_left", exp_q.size(), 0);

    // Zero count
    clear_stats();
    issue(100, 0, 12'h00F, 12'h00F);
    wait_quiet("zero_timeout", 50);
    check("zero_done_cnt", done_cnt, 1);
    check("zero_err_cnt", err_cnt, 0);
    check("zero_we_cycles", we_cycles, 0);

    // Cancel on the 5th write cycle, with an ignored start in the same cycle
    clear_stats();
    push_run(200, 5, 12'h0AB, 12'h0AB);
    issue(200, 100, 12'h0AB, 12'h0AB);
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.cancel     = 1'b1;
    bus.start      = 1'b1;
    bus.start_addr = AW'(0);
    bus.count      = AW'(5);
    bus.fill_color = 12'h555;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    bus.start  = 1'b0;
    check("cancel_we_off", {31'd0, bus.mem_we}, 32'd0);
    check("cancel_busy_off", {31'd0, bus.busy}, 32'd0);
    check("cancel_state", {30'd0, state_dbg}, {30'd0, BW_IDLE});
    repeat (10) @(posedge clk);
    #1;
    check("cancel_accepts", accepts, 5);
    check("cancel_we_cycles", we_cycles, 5);
    check("cancel_done_cnt", done_cnt, 0);
    check("cancel_err_cnt", err_cnt, 0);
    check("cancel_left", exp_q.size(), 0);

`ifdef BITMAP_WR_CHECKER_EN
    // Checkerboard: 5..8 alternate alt/fill on address parity
    clear_stats();
    exp_q.push_back({12'd5, 12'hFFF});
    exp_q.push_back({12'd6, 12'h000});
    exp_q.push_back({12'd7, 12'hFFF});
    exp_q.push_back({12'd8, 12'h000});
    issue(5, 4, 12'h000, 12'hFFF);
    wait_quiet("chk_timeout", 50);
    check("chk_accepts", accepts, 4);
    check("chk_done_cnt", done_cnt, 1);
    check("chk_left", exp_q.size(), 0);
`endif

    // Asynchronous reset in the middle of a fill
    clear_stats();
    push_run(300, 3, 12'h777, 12'h777);
    issue(300, 50, 12'h777, 12'h777);
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_we", {31'd0, bus.mem_we}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_addr", {20'd0, bus.mem_addr}, 32'd0);
    check("arst_state", {30'd0, state_dbg}, {30'd0, BW_IDLE});
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("arst_accepts", accepts, 3);
    check("arst_done_cnt", done_cnt, 0);
    check("arst_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
